key_loader: RTL

//  Upstream feeder for key_creation. Accepts a 128-bit AES cipher key as
//  KEY_WIDTH/WORD_WIDTH words over a valid/ready handshake and assembles it.

---
 rtl/key_loader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/key_loader.sv
// key_loader: collects a 128-bit AES key as 32-bit words and launches key_creation.
// Latency: startTransition one cycle after the last word; keysReady KEY_GEN_CYCLES later.
// Backpressure: wordReady is registered and is high only while collecting; words offered while it is low are dropped.
module key_loader #(
  parameter int KEY_WIDTH      = 128,
  parameter int WORD_WIDTH     = 32,
  parameter int KEY_GEN_CYCLES = 22
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] wordIn,
  input  logic                  wordValid,
  output logic                  wordReady,
  output logic [KEY_WIDTH-1:0]  roundKeyInput,
  output logic                  startTransition,
  output logic                  busy,
  output logic                  keysReady
);

  localparam int NWORDS = KEY_WIDTH / WORD_WIDTH;
  localparam int WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CW     = $clog2(KEY_GEN_CYCLES + 1);

  localparam logic [WCW-1:0] LAST_WORD = WCW'(NWORDS - 1);
  localparam logic [CW-1:0]  GEN_LAST  = CW'(KEY_GEN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_FLUSH   = 2'd0,
    S_COLLECT = 2'd1,
    S_START   = 2'd2,
    S_WAIT    = 2'd3
  } state_t;

  state_t                state_q;
  logic [WCW-1:0]        word_cnt_q;
  logic [CW-1:0]         wait_cnt_q;
  logic                  word_ready_q;
  logic [KEY_WIDTH-1:0]  key_q;
  logic [KEY_WIDTH-1:0]  key_d;
  logic                  start_q;
  logic                  busy_q;
  logic                  keys_ready_q;
  logic                  accept;

  // A word moves only when the registered ready is up, which happens only in COLLECT.
  assign accept = word_ready_q & wordValid;

  // New words enter at the LSB so the first word ends up in the top bits.
  assign key_d = {key_q[KEY_WIDTH-WORD_WIDTH-1:0], wordIn};

  // Control FSM with all outputs registered.
  // FLUSH waits out a key_creation run that may have been in flight before reset,
  // since key_creation itself has no reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_FLUSH;
      word_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      word_ready_q <= 1'b0;
      key_q        <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      keys_ready_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_FLUSH: begin
          if (wait_cnt_q == GEN_LAST) begin
            wait_cnt_q   <= '0;
            word_ready_q <= 1'b1;
            state_q      <= S_COLLECT;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        S_COLLECT: begin
          if (accept) begin
            key_q <= key_d;
            // First word of a new key: key_creation outputs are about to be overwritten.
            if (word_cnt_q == '0) begin
              busy_q       <= 1'b1;
              keys_ready_q <= 1'b0;
            end
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_q   <= '0;
              word_ready_q <= 1'b0;
              start_q      <= 1'b1;
              state_q      <= S_START;
            end else begin
              word_cnt_q <= word_cnt_q + WCW'(1);
            end
          end
        end
        S_START: begin
          wait_cnt_q <= GEN_LAST;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q == '0) begin
            keys_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            word_ready_q <= 1'b1;
            state_q      <= S_COLLECT;
          end else begin
            wait_cnt_q <= wait_cnt_q - CW'(1);
          end
        end
        default: begin
          state_q      <= S_FLUSH;
          word_cnt_q   <= '0;
          wait_cnt_q   <= '0;
          word_ready_q <= 1'b0;
          busy_q       <= 1'b0;
          keys_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign wordReady       = word_ready_q;
  assign roundKeyInput   = key_q;
  assign startTransition = start_q;
  assign busy            = busy_q;
  assign keysReady       = keys_ready_q;

endmodule
